// File: rtl/cordic_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one in-order CORDIC core.
// Issue and return paths are combinational; a tag FIFO routes each result back to its requester.
module cordic_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int XY_W      = 16,
    parameter int ANGLE_W   = 32,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*XY_W-1:0]      req_x,
    input  logic [NUM_REQ*XY_W-1:0]      req_y,
    input  logic [NUM_REQ*ANGLE_W-1:0]   req_z,
    output logic                         core_in_valid,
    input  logic                         core_in_ready,
    output logic [XY_W-1:0]              core_x_in,
    output logic [XY_W-1:0]              core_y_in,
    output logic [ANGLE_W-1:0]           core_z_in,
    input  logic                         core_out_valid,
    output logic                         core_out_ready,
    input  logic [XY_W-1:0]              core_cos,
    input  logic [XY_W-1:0]              core_sin,
    input  logic [XY_W-1:0]              core_mag,
    input  logic [ANGLE_W-1:0]           core_theta,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [XY_W-1:0]              rsp_cos,
    output logic [XY_W-1:0]              rsp_sin,
    output logic [XY_W-1:0]              rsp_mag,
    output logic [ANGLE_W-1:0]           rsp_theta,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         err_orphan
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   tag_mem [TAG_DEPTH];

    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [XY_W-1:0]    x_arr [NUM_REQ];
    logic [XY_W-1:0]    y_arr [NUM_REQ];
    logic [ANGLE_W-1:0] z_arr [NUM_REQ];
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_found;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   head;
    logic               full, empty, in_hs, pop, orphan;

    // cand[i] is the i-th index in round-robin search order starting at rr_ptr_q
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign cand[gi]      = IDX_W'((int'(rr_ptr_q) + gi) % NUM_REQ);
            assign x_arr[gi]     = req_x[gi*XY_W +: XY_W];
            assign y_arr[gi]     = req_y[gi*XY_W +: XY_W];
            assign z_arr[gi]     = req_z[gi*ANGLE_W +: ANGLE_W];
            assign req_ready[gi] = in_hs && (grant == IDX_W'(gi));
            assign rsp_valid[gi] = !rst && core_out_valid && !empty && (head == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        arb_idx   = rr_ptr_q;
        arb_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_found && req_valid[cand[i]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[i];
            end
        end
    end

    // A stalled offer keeps its grant so a later, higher-priority request cannot steal it
    assign grant          = lock_q ? lock_idx_q : arb_idx;
    assign full           = (count_q == CNT_W'(TAG_DEPTH));
    assign empty          = (count_q == '0);
    assign core_in_valid  = !rst && (|req_valid) && !full;
    assign in_hs          = core_in_valid && core_in_ready;
    assign core_x_in      = x_arr[grant];
    assign core_y_in      = y_arr[grant];
    assign core_z_in      = z_arr[grant];

    assign head           = tag_mem[rd_ptr_q];
    assign core_out_ready = !rst && (empty || rsp_ready[head]);
    assign pop            = core_out_valid && core_out_ready && !empty;
    assign orphan         = !rst && core_out_valid && empty;

    assign rsp_cos        = core_cos;
    assign rsp_sin        = core_sin;
    assign rsp_mag        = core_mag;
    assign rsp_theta      = core_theta;
    assign outstanding    = count_q;
    assign err_orphan     = err_q;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        if (in_hs) begin
            lock_d   = 1'b0;
            rr_ptr_d = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (core_in_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({in_hs, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (orphan) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read between push and pop
    always_ff @(posedge clk) begin
        if (in_hs) begin
            tag_mem[wr_ptr_q] <= grant;
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed and randomized bench for cordic_arbiter; the bench plays the CORDIC core and
// checks every cycle against a queue-based model of grants and in-order returns.
module tb_cordic_arbiter;
    localparam int N  = 4;
    localparam int XW = 16;
    localparam int AW = 32;
    localparam int TD = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*XW-1:0] req_x, req_y;
    logic [N*AW-1:0] req_z;
    logic            core_in_valid, core_in_ready;
    logic [XW-1:0]   core_x_in, core_y_in;
    logic [AW-1:0]   core_z_in;
    logic            core_out_valid, core_out_ready;
    logic [XW-1:0]   core_cos, core_sin, core_mag;
    logic [AW-1:0]   core_theta;
    logic [N-1:0]    rsp_valid, rsp_ready;
    logic [XW-1:0]   rsp_cos, rsp_sin, rsp_mag;
    logic [AW-1:0]   rsp_theta;
    logic [$clog2(TD):0] outstanding;
    logic            err_orphan;

    int checks = 0;
    int errors = 0;

    // Model: queue of requester indices in issue order, round-robin start, grant lock, orphan flag
    int mq[$];
    int m_ptr      = 0;
    bit m_lock     = 1'b0;
    int m_lock_idx = 0;
    bit m_err      = 1'b0;

    cordic_arbiter #(.NUM_REQ(N), .XY_W(XW), .ANGLE_W(AW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_x_in(core_x_in), .core_y_in(core_y_in), .core_z_in(core_z_in),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .core_cos(core_cos), .core_sin(core_sin), .core_mag(core_mag), .core_theta(core_theta),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_mag(rsp_mag), .rsp_theta(rsp_theta),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_data();
        req_x      = {$urandom, $urandom};
        req_y      = {$urandom, $urandom};
        req_z      = {$urandom, $urandom, $urandom, $urandom};
        core_cos   = XW'($urandom);
        core_sin   = XW'($urandom);
        core_mag   = XW'($urandom);
        core_theta = $urandom;
    endtask

    // Called at a falling edge with inputs applied: check outputs, advance model, wait one cycle
    task automatic step(input string tag);
        int g;
        int h;
        bit vin;
        bit eor;
        logic [N-1:0] er;
        logic [N-1:0] ev;
        #1;
        if (rst) begin
            chk({tag, "/civ"}, core_in_valid, 0);
            chk({tag, "/req_ready"}, req_ready, 0);
            chk({tag, "/cor"}, core_out_ready, 0);
            chk({tag, "/rsp_valid"}, rsp_valid, 0);
            chk({tag, "/outstanding"}, outstanding, 0);
            chk({tag, "/err"}, err_orphan, 0);
            mq.delete();
            m_ptr  = 0;
            m_lock = 1'b0;
            m_err  = 1'b0;
        end else begin
            vin = (req_valid != '0) && (mq.size() < TD);
            g   = m_lock ? m_lock_idx : rr_pick();
            er  = '0;
            if (vin && core_in_ready) er[g] = 1'b1;
            chk({tag, "/civ"}, core_in_valid, vin);
            chk({tag, "/req_ready"}, req_ready, er);
            if (vin) begin
                chk({tag, "/x"}, core_x_in, req_x[g*XW +: XW]);
                chk({tag, "/y"}, core_y_in, req_y[g*XW +: XW]);
                chk({tag, "/z"}, core_z_in, req_z[g*AW +: AW]);
            end
            ev  = '0;
            eor = 1'b1;
            if (mq.size() > 0) begin
                h   = mq[0];
                eor = rsp_ready[h];
                if (core_out_valid) ev[h] = 1'b1;
            end
            chk({tag, "/rsp_valid"}, rsp_valid, ev);
            chk({tag, "/cor"}, core_out_ready, eor);
            chk({tag, "/outstanding"}, outstanding, mq.size());
            chk({tag, "/err"}, err_orphan, m_err);
            if (core_out_valid) begin
                chk({tag, "/cos"}, rsp_cos, core_cos);
                chk({tag, "/theta"}, rsp_theta, core_theta);
            end
            if (core_out_valid && mq.size() == 0) m_err = 1'b1;
            if (core_out_valid && mq.size() > 0 && rsp_ready[mq[0]]) void'(mq.pop_front());
            if (vin && core_in_ready) begin
                mq.push_back(g);
                m_lock = 1'b0;
                m_ptr  = (g + 1) % N;
            end else if (vin) begin
                m_lock     = 1'b1;
                m_lock_idx = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < TD + 4 && mq.size() > 0; k++) begin
            core_out_valid = 1'b1;
            rand_data();
            step("drain");
        end
        core_out_valid = 1'b0;
        #1;
        chk("drain_empty", outstanding, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_x = '0; req_y = '0; req_z = '0;
        core_in_ready = 1'b0; core_out_valid = 1'b0; rsp_ready = '0;
        core_cos = '0; core_sin = '0; core_mag = '0; core_theta = '0;
        @(negedge clk);
        step("reset0");
        step("reset1");
        rst = 1'b0;

        // Single request routed back to requester 0
        req_valid = 4'b0001; req_x[15:0] = 16'h4000; req_y = '0; req_z[31:0] = 32'h2000_0000;
        core_in_ready = 1'b1; rsp_ready = '1;
        #1;
        chk("single_ready", req_ready, 4'b0001);
        step("single_issue");
        chk("single_out1", outstanding, 1);
        req_valid = '0; core_out_valid = 1'b1;
        core_cos = 16'h2d41; core_sin = 16'h2d41; core_mag = 16'h4000; core_theta = 32'h2000_0000;
        #1;
        chk("single_rsp", rsp_valid, 4'b0001);
        step("single_ret");
        core_out_valid = 1'b0;
        chk("single_out0", outstanding, 0);

        // Fairness with everyone requesting
        req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            rand_data();
            core_out_valid = (mq.size() > 0);
            step("fair");
        end
        drain();

        // Grant lock on requester 2 while requester 0 rises
        rand_data();
        req_valid = 4'b0100; core_in_ready = 1'b0;
        step("lock_req2");
        req_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lock_x", core_x_in, req_x[2*XW +: XW]);
            step("lock_hold");
        end
        core_in_ready = 1'b1;
        #1;
        chk("lock_release", req_ready, 4'b0100);
        step("lock_release");
        req_valid = 4'b1001;
        #1;
        chk("lock_next_grant", req_ready, 4'b1000);
        step("lock_next");
        drain();

        // Backpressure: fill the tag FIFO, then release one result
        rsp_ready = '0; req_valid = '1; core_in_ready = 1'b1;
        for (int k = 0; k < TD + 2; k++) begin
            rand_data();
            core_out_valid = (mq.size() > 0);
            step("bp_fill");
        end
        #1;
        chk("bp_full_civ", core_in_valid, 0);
        chk("bp_full_cnt", outstanding, TD);
        rsp_ready = '1; core_out_valid = 1'b1;
        step("bp_pop");
        rsp_ready = '0;
        #1;
        chk("bp_resume_civ", core_in_valid, 1);
        step("bp_resume");
        drain();

        // Orphan result with nothing pending
        core_out_valid = 1'b1;
        #1;
        chk("orphan_cor", core_out_ready, 1);
        step("orphan");
        core_out_valid = 1'b0;
        step("orphan_sticky");
        chk("orphan_err", err_orphan, 1);

        // Random traffic with an asynchronous reset in the middle
        for (int k = 0; k < 400; k++) begin
            rst            = (k == 200);
            req_valid      = N'($urandom);
            core_in_ready  = ($urandom_range(0, 3) != 0);
            rsp_ready      = N'($urandom);
            core_out_valid = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            rand_data();
            step(rst ? "rst_mid" : "rand");
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
